// File: rtl/proc_pkg.sv
// Shared processor constants: opcode map, instruction field positions,
// NOP encoding, PC width and the fetch/issue state type.
package proc_pkg;

  localparam int PC_W = 12;
  localparam int IW_W = 16;

  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam logic [3:0] OP_MOV = 4'b1011;
  localparam logic [3:0] OP_LD  = 4'b1100;
  localparam logic [3:0] OP_ST  = 4'b1101;
  localparam logic [3:0] OP_BT  = 4'b1110;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RA_LSB = 4;
  localparam int RB_LSB = 0;

  localparam logic [IW_W-1:0] NOP_WORD = 16'hF000;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2
  } state_t;

  function automatic logic [3:0] f_opcode(input logic [IW_W-1:0] w);
    return w[OP_LSB +: 4];
  endfunction

  function automatic logic [3:0] f_rd(input logic [IW_W-1:0] w);
    return w[RD_LSB +: 4];
  endfunction

  function automatic logic [3:0] f_ra(input logic [IW_W-1:0] w);
    return w[RA_LSB +: 4];
  endfunction

  function automatic logic [3:0] f_rb(input logic [IW_W-1:0] w);
    return w[RB_LSB +: 4];
  endfunction

endpackage

// File: rtl/fetch_issue_if.sv
// Fetch/issue bus: instruction memory port, downstream controls and the
// issued instruction fields. master = fetch_issue, slave = memory/decoder side.
interface fetch_issue_if;
  import proc_pkg::*;

  logic            stall;
  logic            cmp_flag;
  logic [PC_W-1:0] imem_addr;
  logic [IW_W-1:0] imem_data;
  logic [3:0]      opcode;
  logic [3:0]      rd;
  logic [3:0]      ra;
  logic [3:0]      rb;
  logic [7:0]      imm;
  logic            issue_valid;

  modport master (
    input  stall, cmp_flag, imem_data,
    output imem_addr, opcode, rd, ra, rb, imm, issue_valid
  );

  modport slave (
    output stall, cmp_flag, imem_data,
    input  imem_addr, opcode, rd, ra, rb, imm, issue_valid
  );
endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard: the issued LD writes a register that the incoming word reads.
module load_use_detect
  import proc_pkg::*;
(
  input  logic [3:0] issued_op,
  input  logic [3:0] issued_rd,
  input  logic [3:0] next_op,
  input  logic [3:0] next_ra,
  input  logic [3:0] next_rb,
  output logic       hazard
);

  logic reads_ra;
  logic reads_rb;

  // Decide which source fields the incoming opcode actually reads.
  always_comb begin
    reads_ra = 1'b1;
    reads_rb = 1'b1;
    case (next_op)
      OP_MOV, OP_BT, OP_NOP: begin
        reads_ra = 1'b0;
        reads_rb = 1'b0;
      end
      OP_NOT, OP_LD: begin
        reads_rb = 1'b0;
      end
      default: begin
        reads_ra = 1'b1;
        reads_rb = 1'b1;
      end
    endcase
    hazard = (issued_op == OP_LD) &&
             ((reads_ra && (next_ra == issued_rd)) ||
              (reads_rb && (next_rb == issued_rd)));
  end

endmodule

// File: rtl/fetch_issue.sv
// Fetch and issue stage: PC sequencing, taken-branch redirect with one bubble,
// load-use bubble with PC hold, and a downstream stall that freezes everything.
module fetch_issue
  import proc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fetch_issue_if.master bus
);

  state_t          state_r;
  logic [PC_W-1:0] pc_r;
  logic [IW_W-1:0] word_r;
  logic            valid_r;
  logic            hazard;
  logic            taken;

  load_use_detect u_load_use_detect (
    .issued_op (f_opcode(word_r)),
    .issued_rd (f_rd(word_r)),
    .next_op   (f_opcode(bus.imem_data)),
    .next_ra   (f_ra(bus.imem_data)),
    .next_rb   (f_rb(bus.imem_data)),
    .hazard    (hazard)
  );

  // A bubble is never valid, so a BT can only be taken once even across a stall.
  assign taken = valid_r && (f_opcode(word_r) == OP_BT) && bus.cmp_flag;

  // PC, issue register and state; reset beats stall beats branch beats hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FILL;
      pc_r    <= 12'h000;
      word_r  <= NOP_WORD;
      valid_r <= 1'b0;
    end else if (bus.stall) begin
      state_r <= state_r;
      pc_r    <= pc_r;
      word_r  <= word_r;
      valid_r <= valid_r;
    end else begin
      case (state_r)
        ST_FILL: begin
          state_r <= ST_RUN;
          pc_r    <= 12'h000;
          word_r  <= NOP_WORD;
          valid_r <= 1'b0;
        end
        ST_RUN, ST_BUBBLE: begin
          if (taken) begin
            state_r <= ST_BUBBLE;
            pc_r    <= word_r[PC_W-1:0];
            word_r  <= NOP_WORD;
            valid_r <= 1'b0;
          end else if (hazard) begin
            state_r <= ST_BUBBLE;
            pc_r    <= pc_r;
            word_r  <= NOP_WORD;
            valid_r <= 1'b0;
          end else begin
            state_r <= ST_RUN;
            pc_r    <= pc_r + 12'd1;
            word_r  <= bus.imem_data;
            valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_FILL;
          pc_r    <= 12'h000;
          word_r  <= NOP_WORD;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr   = pc_r;
  assign bus.opcode      = f_opcode(word_r);
  assign bus.rd          = f_rd(word_r);
  assign bus.ra          = f_ra(word_r);
  assign bus.rb          = f_rb(word_r);
  assign bus.imm         = word_r[7:0];
  assign bus.issue_valid = valid_r;

endmodule

// File: tb/tb_fetch_issue.sv
// Directed bench for fetch_issue: per-cycle expectations are queued as each
// step is driven and popped/compared one time unit after the rising edge.
module tb_fetch_issue;
  import proc_pkg::*;

  logic clk;
  logic rst;
  fetch_issue_if bus ();

  fetch_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: the word addressed during a cycle is read out on the
  // falling edge, ready for the next rising edge.
  logic [15:0] mem [0:4095];
  always @(negedge clk) bus.imem_data <= mem[bus.imem_addr];

  typedef struct {
    string       tag;
    logic [36:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h7000;
  endtask

  // Queue the expected post-edge outputs, clock once, then compare.
  task automatic cyc(input string tag, input logic v, input logic [15:0] w,
                     input logic [11:0] a);
    exp_t e;
    exp_t got;
    logic [36:0] obs;
    e.tag = tag;
    e.exp = {v, w, w[7:0], a};
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    obs = {bus.issue_valid, bus.opcode, bus.rd, bus.ra, bus.rb, bus.imm, bus.imem_addr};
    checks++;
    assert (obs === got.exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", got.tag, obs, got.exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.cmp_flag = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.cmp_flag = 1'b0;
    clear_mem();

    // Reset state and basic sequential issue, including a fetched NOP.
    mem[0] = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'hF000;
    do_reset();
    cyc("reset0", 1'b0, 16'hF000, 12'h000);
    cyc("reset1", 1'b0, 16'hF000, 12'h000);
    rst = 1'b0;
    cyc("fill", 1'b0, 16'hF000, 12'h000);
    cyc("first_word", 1'b1, 16'h1123, 12'h001);
    cyc("second_word", 1'b1, 16'h2456, 12'h002);
    cyc("fetched_nop", 1'b1, 16'hF000, 12'h003);

    // Load-use hazards on ra and rb, and the non-hazard cases.
    clear_mem();
    mem[0] = 16'hC312; mem[1] = 16'h1531; mem[2] = 16'hC300; mem[3] = 16'h1513;
    mem[4] = 16'hC300; mem[5] = 16'hB37F; mem[6] = 16'hC300; mem[7] = 16'h6103;
    do_reset();
    rst = 1'b0;
    cyc("lu_fill", 1'b0, 16'hF000, 12'h000);
    cyc("lu_ld_a", 1'b1, 16'hC312, 12'h001);
    cyc("lu_bubble_ra", 1'b0, 16'hF000, 12'h001);
    cyc("lu_add_ra", 1'b1, 16'h1531, 12'h002);
    cyc("lu_ld_b", 1'b1, 16'hC300, 12'h003);
    cyc("lu_bubble_rb", 1'b0, 16'hF000, 12'h003);
    cyc("lu_add_rb", 1'b1, 16'h1513, 12'h004);
    cyc("lu_ld_c", 1'b1, 16'hC300, 12'h005);
    cyc("lu_mov_nobubble", 1'b1, 16'hB37F, 12'h006);
    cyc("lu_ld_d", 1'b1, 16'hC300, 12'h007);
    cyc("lu_not_nobubble", 1'b1, 16'h6103, 12'h008);
    cyc("lu_after", 1'b1, 16'h7000, 12'h009);

    // Untaken and taken branches, then a taken branch held by stall.
    clear_mem();
    mem[0] = 16'hE040; mem[1] = 16'h7111; mem[2] = 16'hE040; mem[3] = 16'h7222;
    mem[12'h040] = 16'h7444; mem[12'h041] = 16'h7555; mem[12'h042] = 16'hE010;
    mem[12'h043] = 16'h7666; mem[12'h010] = 16'h7777; mem[12'h011] = 16'h7888;
    do_reset();
    rst = 1'b0;
    cyc("br_fill", 1'b0, 16'hF000, 12'h000);
    cyc("br_bt1", 1'b1, 16'hE040, 12'h001);
    bus.cmp_flag = 1'b0;
    cyc("br_untaken", 1'b1, 16'h7111, 12'h002);
    cyc("br_bt2", 1'b1, 16'hE040, 12'h003);
    bus.cmp_flag = 1'b1;
    cyc("br_taken_bubble", 1'b0, 16'hF000, 12'h040);
    bus.cmp_flag = 1'b0;
    cyc("br_target", 1'b1, 16'h7444, 12'h041);
    cyc("br_target_next", 1'b1, 16'h7555, 12'h042);
    cyc("br_bt3", 1'b1, 16'hE010, 12'h043);
    bus.cmp_flag = 1'b1;
    bus.stall = 1'b1;
    cyc("stall_1", 1'b1, 16'hE010, 12'h043);
    cyc("stall_2", 1'b1, 16'hE010, 12'h043);
    cyc("stall_3", 1'b1, 16'hE010, 12'h043);
    bus.stall = 1'b0;
    cyc("stall_redirect", 1'b0, 16'hF000, 12'h010);
    cyc("stall_target", 1'b1, 16'h7777, 12'h011);
    cyc("stall_once", 1'b1, 16'h7888, 12'h012);

    // Reset mid-stream wins over a simultaneous stall.
    bus.stall = 1'b1;
    rst = 1'b1;
    cyc("mid_reset", 1'b0, 16'hF000, 12'h000);
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.cmp_flag = 1'b0;
    cyc("mid_reset_fill", 1'b0, 16'hF000, 12'h000);

    // PC wraparound from 0xFFF to 0x000.
    clear_mem();
    mem[0] = 16'hEFFE; mem[12'hFFE] = 16'h7AAA; mem[12'hFFF] = 16'h7BBB;
    do_reset();
    rst = 1'b0;
    cyc("wrap_fill", 1'b0, 16'hF000, 12'h000);
    cyc("wrap_bt", 1'b1, 16'hEFFE, 12'h001);
    bus.cmp_flag = 1'b1;
    cyc("wrap_bubble", 1'b0, 16'hF000, 12'hFFE);
    bus.cmp_flag = 1'b0;
    cyc("wrap_ffe", 1'b1, 16'h7AAA, 12'hFFF);
    cyc("wrap_to_zero", 1'b1, 16'h7BBB, 12'h000);
    cyc("wrap_reissue", 1'b1, 16'hEFFE, 12'h001);
    cyc("wrap_seq", 1'b1, 16'h7000, 12'h002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_issue.md
FETCH_ISSUE -- requirements
Module: fetch_issue

Interface
REQ-001 The block SHALL be clocked by one clock, and its reset SHALL be synchronous and active-high.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 stall  in  1  downstream hold; freezes all block state for the cycle.
REQ-005 cmp_flag  in  1  result flag of the last CMP; sampled only while a BT is on the issue outputs.
REQ-006 imem_addr  out  12  instruction memory word address (the PC).
REQ-007 imem_data  in  16  instruction word; synchronous memory, valid one cycle after imem_addr.
REQ-008 opcode  out  4  issued opcode; feeds the control decoder.
REQ-009 rd, ra, rb  out  4 each  issued register fields: instr[11:8], [7:4], [3:0].
REQ-010 imm  out  8  issued instr[7:0]; used by MOV.
REQ-011 issue_valid  out  1  high when the issue outputs carry a real instruction, low for a bubble.

Function
REQ-012 Opcode map: 1000 CMP, 1011 MOV, 1100 LD, 1101 ST, 1110 BT, 1111 NOP, 0110 NOT; all other values are ALU ops.
REQ-013 The issue outputs SHALL be a register loaded from imem_data; latency from address to issue is 2 cycles.
REQ-014 States: FILL (first cycle after reset; no valid data yet), RUN, BUBBLE (a NOP is issued).
REQ-015 FILL: issue NOP with issue_valid=0, hold imem_addr=0, then go to RUN.
REQ-016 RUN, no hazard: load imem_data into the issue register with issue_valid=1; PC increments by 1 modulo 4096 (0xFFF wraps to 0x000).
REQ-017 Taken branch: when opcode=BT, issue_valid=1 and cmp_flag=1, set PC to instr[11:0] of the BT.
REQ-018 On a taken branch, discard the word in imem_data and issue one NOP bubble; the target issues 2 cycles after BT is issued.
REQ-019 Untaken branch: when cmp_flag=0, the BT SHALL behave as a plain issue with no bubble.
REQ-020 Load-use hazard: issued instruction is LD (rd=x) and the word in imem_data reads x.
REQ-021 The incoming word reads ra unless its opcode is MOV, BT or NOP.
REQ-022 The incoming word reads rb unless its opcode is NOT, MOV, LD, BT or NOP.
REQ-023 On a load-use hazard, issue one NOP (issue_valid=0) and hold the PC; the same word re-issues on the next cycle.
REQ-024 A NOP inserted by the block SHALL be encoded as opcode=1111 with all other fields 0 and issue_valid=0.
REQ-025 Priority: stall > taken branch > load-use hazard > normal advance.
REQ-026 While stall=1: PC, issue register and state SHALL hold; imem_addr SHALL hold, so imem_data is re-presented.
REQ-027 A taken BT held by stall SHALL redirect on the first unstalled cycle, and only once.
REQ-028 A NOP fetched from memory SHALL issue with issue_valid=1; it is not treated as a bubble.

Reset
REQ-029 While rst=1: PC=0, imem_addr=0, opcode=1111, rd=ra=rb=0, imm=0, issue_valid=0, state=FILL.
REQ-030 Reset asserted mid-operation SHALL win over stall, branch and hazard in the same cycle; pending redirects and bubbles are lost.

Structure
REQ-031 Opcode constants, field bit positions, the NOP encoding and the PC width SHALL live in the shared package proc_pkg.
REQ-032 The proc_pkg constants SHALL be reused by the control decoder.
REQ-033 Hazard detection (REQ-020 to REQ-022) SHALL be the combinational sub-module load_use_detect.
REQ-034 load_use_detect inputs: issued opcode, issued rd, imem_data opcode/ra/rb; output: hazard.

Verification
REQ-035 Reset release, then words 0x1123, 0x2456 at addresses 0 and 1 -> issue_valid first high 2 cycles after release with opcode=1, rd=1, ra=2, rb=3; then opcode=2, rd=4, ra=5, rb=6.
REQ-036 LD r3 (0xC3..) followed by ADD r5,r3,r1 -> one bubble (opcode=1111, issue_valid=0), the ADD issued next cycle, and the PC held for one cycle.
REQ-037 LD r3 followed by MOV r3,#0x7F -> no bubble.
REQ-038 BT 0x040 with cmp_flag=1 -> next cycle a bubble and imem_addr=0x040; the word at 0x040 is issued the cycle after.
REQ-039 Same BT with cmp_flag=0 -> no bubble and sequential addresses.
REQ-040 PC=0xFFF -> the next imem_addr is 0x000.
REQ-041 stall held 3 cycles during a pending taken BT -> outputs frozen for 3 cycles, then exactly one redirect.
REQ-042 rst pulsed mid-stream -> all outputs take the REQ-029 values the next cycle.
